// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Responder side of the cache-control protocol. Arbitrates the
//                dcache (read/write) and icache (read only) onto a single-port
//                variable-latency RAM and drives each cache's wait/load lines.
//                Outputs are combinational from the grant state, so a request
//                seen in IDLE is granted on the next edge and can complete in
//                the first granted cycle if the RAM reports ACCESS.
//  Options     : MEM_ARB_ROUND_ROBIN_EN - alternate priority between caches
//                after each completed access (default: dcache always wins).
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  // dcache side
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  // icache side
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  // RAM side
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate
);

  // RAM status encoding; only ACCESS completes a transfer, ERROR behaves as BUSY
  localparam logic [1:0] C_RAM_ACCESS = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    D_ACC = 2'd1,
    I_ACC = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic w_d_req;       // dcache wants the RAM (read or write)
  logic w_ram_access;  // RAM reports the access done this cycle
  logic w_pick_i;      // icache wins a tie in IDLE

  assign w_d_req      = dREN | dWEN;
  assign w_ram_access = (ramstate == C_RAM_ACCESS);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // 1 = icache holds priority for the next tie, 0 = dcache
  logic prio_i_q;
  logic prio_i_d;

  // Priority flips only on a completed access; aborts leave it untouched
  always_comb begin
    prio_i_d = prio_i_q;
    if (state_q == D_ACC && w_d_req && w_ram_access) begin
      prio_i_d = 1'b1;
    end else if (state_q == I_ACC && iREN && w_ram_access) begin
      prio_i_d = 1'b0;
    end
  end

  // Priority flag register, starts with dcache favoured
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      prio_i_q <= 1'b0;
    end else begin
      prio_i_q <= prio_i_d;
    end
  end

  assign w_pick_i = prio_i_q;
`else
  assign w_pick_i = 1'b0;
`endif

  // Grant state register; reset drops any in-flight grant immediately
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and all outputs; waits idle high, loads zero outside completion
  always_comb begin
    state_d  = state_q;
    dwait    = 1'b1;
    iwait    = 1'b1;
    dload    = '0;
    iload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;

    unique case (state_q)
      IDLE: begin
        // dcache wins unless the icache also asks and currently holds priority
        if (w_d_req && !(iREN && w_pick_i)) begin
          state_d = D_ACC;
        end else if (iREN) begin
          state_d = I_ACC;
        end
      end

      D_ACC: begin
        ramaddr  = daddr;
        ramstore = dstore;
        // a write takes precedence when both read and write are requested
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        if (!w_d_req) begin
          // requester withdrew before completion: abort without a pulse
          state_d = IDLE;
        end else if (w_ram_access) begin
          dwait   = 1'b0;
          if (!dWEN) begin
            dload = ramload;
          end
          state_d = IDLE;
        end
      end

      I_ACC: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        if (!iREN) begin
          state_d = IDLE;
        end else if (w_ram_access) begin
          iwait   = 1'b0;
          iload   = ramload;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter. A behavioural model that
//                tracks which cache currently owns the RAM predicts every
//                output each cycle; directed sequences pin the model with
//                literal expectations, then randomized traffic follows.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [1:0] FREE = 2'b00, BUSY = 2'b01, ACCESS = 2'b10, ERROR = 2'b11;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          dREN, dWEN, iREN;
  logic [AW-1:0] daddr, iaddr, ramaddr;
  logic [DW-1:0] dstore, dload, iload, ramstore, ramload;
  logic          dwait, iwait, ramREN, ramWEN;
  logic [1:0]    ramstate;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK(clk), .RST(rst),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
  );

  int vectors     = 0;
  int miscompares = 0;

  // model: who owns the RAM (0 nobody, 1 dcache, 2 icache) and tie priority
  int  owner   = 0;
  bit  favor_i = 1'b0;

  // observation counters for directed checks
  int  n_dpulse, n_ipulse, n_ren, n_wen;
  logic [DW-1:0] last_dload, last_iload;
  byte cq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_obs();
    n_dpulse = 0; n_ipulse = 0; n_ren = 0; n_wen = 0;
    last_dload = '0; last_iload = '0;
    cq.delete();
  endtask

  // One clock: drive on the falling edge, check mid-low-phase, advance model
  task automatic cycle(input logic r, input logic dr, input logic dw,
                       input logic [AW-1:0] da, input logic [DW-1:0] ds,
                       input logic ir, input logic [AW-1:0] ia,
                       input logic [1:0] rs, input logic [DW-1:0] rl);
    logic          e_dwait, e_iwait, e_ren, e_wen;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_store, e_dload, e_iload;
    bit            d_req, done;
    @(negedge clk);
    rst = r; dREN = dr; dWEN = dw; daddr = da; dstore = ds;
    iREN = ir; iaddr = ia; ramstate = rs; ramload = rl;
    #2;
    d_req = dr | dw;
    if (r) owner = 0;
    e_dwait = 1'b1; e_iwait = 1'b1; e_ren = 1'b0; e_wen = 1'b0;
    e_addr = '0; e_store = '0; e_dload = '0; e_iload = '0;
    done = (rs == ACCESS);
    if (owner == 1) begin
      e_addr = da; e_store = ds; e_wen = dw; e_ren = dr & ~dw;
      if (d_req && done) begin
        e_dwait = 1'b0;
        e_dload = dw ? '0 : rl;
      end
    end else if (owner == 2) begin
      e_addr = ia; e_ren = ir;
      if (ir && done) begin
        e_iwait = 1'b0;
        e_iload = rl;
      end
    end
    chk("dwait",    {31'd0, dwait},  {31'd0, e_dwait});
    chk("iwait",    {31'd0, iwait},  {31'd0, e_iwait});
    chk("ramREN",   {31'd0, ramREN}, {31'd0, e_ren});
    chk("ramWEN",   {31'd0, ramWEN}, {31'd0, e_wen});
    chk("ramaddr",  ramaddr,  e_addr);
    chk("ramstore", ramstore, e_store);
    chk("dload",    dload,    e_dload);
    chk("iload",    iload,    e_iload);
    chk("one_wait_low", {31'd0, (!dwait && !iwait)}, 32'd0);
    chk("one_strobe",   {31'd0, (ramREN && ramWEN)}, 32'd0);
    // observations
    if (!dwait) begin n_dpulse++; last_dload = dload; cq.push_back(8'h64); end
    if (!iwait) begin n_ipulse++; last_iload = iload; cq.push_back(8'h69); end
    if (ramREN) n_ren++;
    if (ramWEN) n_wen++;
    // model advance for the coming rising edge
    if (r) begin
      owner = 0; favor_i = 1'b0;
    end else if (owner == 0) begin
      if (d_req && ir) owner = (RR && favor_i) ? 2 : 1;
      else if (d_req) owner = 1;
      else if (ir)    owner = 2;
    end else if (owner == 1) begin
      if (!d_req) owner = 0;
      else if (done) begin owner = 0; favor_i = 1'b1; end
    end else begin
      if (!ir) owner = 0;
      else if (done) begin owner = 0; favor_i = 1'b0; end
    end
  endtask

  byte exp_seq[4];

  initial begin
    bit          r_dr, r_dw, r_ir, r_rst;
    logic [1:0]  r_rs;
    rst = 1'b1; dREN = 1'b0; dWEN = 1'b0; iREN = 1'b0;
    daddr = '0; iaddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
    clear_obs();

    // Reset held with a pending dcache read
    cycle(1, 1, 0, 32'h100, 0, 0, 0, BUSY, 0);
    chk("rst_dwait", {31'd0, dwait}, 32'd1);
    chk("rst_iwait", {31'd0, iwait}, 32'd1);
    chk("rst_ramREN", {31'd0, ramREN}, 32'd0);
    chk("rst_ramaddr", ramaddr, 32'd0);
    cycle(0, 1, 0, 32'h100, 0, 0, 0, BUSY, 0);
    chk("post_rst_idle_ren", {31'd0, ramREN}, 32'd0);
    cycle(0, 1, 0, 32'h100, 0, 0, 0, BUSY, 0);
    chk("post_rst_dacc_ren", {31'd0, ramREN}, 32'd1);
    // dcache withdraws mid-access: abort, no pulse
    cycle(0, 0, 0, 32'h100, 0, 0, 0, BUSY, 0);
    chk("abort_ren", {31'd0, ramREN}, 32'd0);
    chk("abort_dwait", {31'd0, dwait}, 32'd1);
    cycle(0, 0, 0, 0, 0, 0, 0, FREE, 0);

    // Read 0x100: one grant cycle, 3 BUSY, then ACCESS
    clear_obs();
    cycle(0, 1, 0, 32'h100, 0, 0, 0, FREE, 0);
    repeat (3) cycle(0, 1, 0, 32'h100, 0, 0, 0, BUSY, 0);
    cycle(0, 1, 0, 32'h100, 0, 0, 0, ACCESS, 32'hDEADBEEF);
    cycle(0, 0, 0, 0, 0, 0, 0, FREE, 32'h55);
    chk("rd_ren_cycles", n_ren, 32'd4);
    chk("rd_dpulses", n_dpulse, 32'd1);
    chk("rd_dload", last_dload, 32'hDEADBEEF);

    // Write with read also asserted: write wins
    clear_obs();
    cycle(0, 1, 1, 32'h200, 32'h12345678, 0, 0, FREE, 0);
    cycle(0, 1, 1, 32'h200, 32'h12345678, 0, 0, ACCESS, 32'hAAAA);
    chk("wr_ramWEN", {31'd0, ramWEN}, 32'd1);
    chk("wr_ramREN", {31'd0, ramREN}, 32'd0);
    chk("wr_ramstore", ramstore, 32'h12345678);
    chk("wr_dwait", {31'd0, dwait}, 32'd0);
    cycle(0, 0, 0, 0, 0, 0, 0, FREE, 0);
    chk("wr_dpulses", n_dpulse, 32'd1);
    chk("wr_wen_cycles", n_wen, 32'd1);

    // Contention: both caches requesting, 1-cycle RAM, from fresh reset
    cycle(1, 0, 0, 0, 0, 0, 0, FREE, 0);
    clear_obs();
    for (int k = 0; k < 8; k++)
      cycle(0, 1, 0, 32'h300 + k, 0, 1, 32'h400 + k, ACCESS, 32'h1000 + k);
    cycle(0, 0, 0, 0, 0, 0, 0, FREE, 0);
    if (RR) begin exp_seq[0] = 8'h64; exp_seq[1] = 8'h69; exp_seq[2] = 8'h64; exp_seq[3] = 8'h69; end
    else    begin exp_seq[0] = 8'h64; exp_seq[1] = 8'h64; exp_seq[2] = 8'h64; exp_seq[3] = 8'h64; end
    chk("cont_count", cq.size(), 32'd4);
    for (int k = 0; k < 4; k++)
      if (k < cq.size()) chk("cont_order", {24'd0, cq[k]}, {24'd0, exp_seq[k]});

    // Quiet bus for 10 cycles
    cycle(1, 0, 0, 0, 0, 0, 0, FREE, 0);
    clear_obs();
    for (int k = 0; k < 10; k++) begin
      cycle(0, 0, 0, 32'h77, 32'h88, 0, 0, ACCESS, 32'h99);
      chk("quiet_dwait", {31'd0, dwait}, 32'd1);
    end
    chk("quiet_strobes", n_ren + n_wen, 32'd0);

    // icache abort during BUSY, then ERROR x5 followed by ACCESS
    clear_obs();
    cycle(0, 0, 0, 0, 0, 1, 32'h500, FREE, 0);
    repeat (2) cycle(0, 0, 0, 0, 0, 1, 32'h500, BUSY, 0);
    cycle(0, 0, 0, 0, 0, 0, 32'h500, BUSY, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, FREE, 0);
    chk("iabort_pulses", n_ipulse, 32'd0);
    cycle(0, 0, 0, 0, 0, 1, 32'h600, FREE, 0);
    repeat (5) cycle(0, 0, 0, 0, 0, 1, 32'h600, ERROR, 32'hBAD);
    cycle(0, 0, 0, 0, 0, 1, 32'h600, ACCESS, 32'hC0FFEE);
    cycle(0, 0, 0, 0, 0, 0, 0, FREE, 0);
    chk("ierr_pulses", n_ipulse, 32'd1);
    chk("ierr_iload", last_iload, 32'hC0FFEE);

    // Randomized traffic with sticky requests and occasional reset
    r_dr = 0; r_dw = 0; r_ir = 0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(3) == 0) r_dr = ~r_dr;
      if ($urandom_range(5) == 0) r_dw = ~r_dw;
      if ($urandom_range(3) == 0) r_ir = ~r_ir;
      r_rst = ($urandom_range(199) == 0);
      r_rs  = 2'($urandom_range(3));
      cycle(r_rst, r_dr, r_dw, $urandom, $urandom, r_ir, $urandom, r_rs, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
